// File: rtl/fb_capture_ctrl.sv
// Frame buffer port-A write sequencer for the QR reader. It either passes pixels
// through live, or captures one complete frame and freezes it until the decoder
// releases it or a frame-count timeout expires.
module fb_capture_ctrl #(
    parameter int unsigned WIDTH          = 640,
    parameter int unsigned HEIGHT         = 480,
    parameter int unsigned ADDR_W         = 19,
    parameter int unsigned TIMEOUT_FRAMES = 60
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              mode_live_in,
    input  logic              capture_req_in,
    input  logic              pix_valid_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              pix_in,
    input  logic              frame_done_in,
    input  logic              scan_done_in,
    output logic              fb_we_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic              fb_din_out,
    output logic              frame_ready_out,
    output logic              busy_out,
    output logic [1:0]        state_out,
    output logic [7:0]        frames_captured_out,
    output logic              err_short_out,
    output logic              timeout_out
);

    localparam int unsigned HOLD_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

    localparam logic [10:0]       H_LIM     = 11'(WIDTH);
    localparam logic [9:0]        V_LIM     = 10'(HEIGHT);
    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [ADDR_W-1:0] CNT_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARM     = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_HOLD    = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]         frames_q, frames_d;
    logic               err_short_d, timeout_d;

    logic               accept_c;
    logic [ADDR_W-1:0]  pix_cnt_fin_c;

    // write pipeline registers
    logic               we1_q, pix1_q;
    logic [ADDR_W-1:0]  row_base1_q, hcount1_q;
    logic               we2_q, din2_q;
    logic [ADDR_W-1:0]  addr2_q;

    // registered status outputs
    logic               frame_ready_q, busy_q, err_short_q, timeout_q;
    logic [1:0]         state_out_q;

    // Pixel accept: in range, and either live pass-through (IDLE/ARM) or capturing.
    always_comb begin
        accept_c = 1'b0;
        if (pix_valid_in && (hcount_in < H_LIM) && (vcount_in < V_LIM)) begin
            if (state_q == ST_CAPTURE) begin
                accept_c = 1'b1;
            end else if ((state_q == ST_IDLE || state_q == ST_ARM) && mode_live_in) begin
                accept_c = 1'b1;
            end
        end
    end

    // Capture pixel count including any pixel accepted this cycle, saturating.
    always_comb begin
        pix_cnt_fin_c = pix_cnt_q;
        if (state_q == ST_CAPTURE && accept_c && pix_cnt_q != CNT_MAX) begin
            pix_cnt_fin_c = pix_cnt_q + ADDR_W'(1);
        end
    end

    // Next-state and counter/pulse logic.
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        frames_d    = frames_q;
        err_short_d = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_req_in) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (frame_done_in) begin
                    state_d   = ST_CAPTURE;
                    pix_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                pix_cnt_d = pix_cnt_fin_c;
                if (frame_done_in) begin
                    pix_cnt_d = '0;
                    if (pix_cnt_fin_c == FRAME_PIX) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                        frames_d   = frames_q + 8'd1;
                    end else begin
                        err_short_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (scan_done_in) begin
                    state_d = ST_IDLE;
                end else if (frame_done_in) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            frames_q      <= '0;
            err_short_q   <= 1'b0;
            timeout_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            state_out_q   <= 2'b00;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            frames_q      <= frames_d;
            err_short_q   <= err_short_d;
            timeout_q     <= timeout_d;
            frame_ready_q <= (state_d == ST_HOLD);
            busy_q        <= (state_d == ST_ARM) || (state_d == ST_CAPTURE);
            state_out_q   <= state_d;
        end
    end

    // Stage 1: row base product, column and pixel data.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            we1_q       <= 1'b0;
            pix1_q      <= 1'b0;
            row_base1_q <= '0;
            hcount1_q   <= '0;
        end else begin
            we1_q       <= accept_c;
            pix1_q      <= pix_in;
            row_base1_q <= ADDR_W'(WIDTH) * ADDR_W'(vcount_in);
            hcount1_q   <= ADDR_W'(hcount_in);
        end
    end

    // Stage 2: final address sum and write strobe.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            we2_q   <= 1'b0;
            din2_q  <= 1'b0;
            addr2_q <= '0;
        end else begin
            we2_q   <= we1_q;
            din2_q  <= pix1_q;
            addr2_q <= row_base1_q + hcount1_q;
        end
    end

    assign fb_we_out           = we2_q;
    assign fb_addr_out         = addr2_q;
    assign fb_din_out          = din2_q;
    assign frame_ready_out     = frame_ready_q;
    assign busy_out            = busy_q;
    assign state_out           = state_out_q;
    assign frames_captured_out = frames_q;
    assign err_short_out       = err_short_q;
    assign timeout_out         = timeout_q;

endmodule

// File: tb/tb_fb_capture_ctrl.sv
// Directed bench for fb_capture_ctrl on a small 8x4 frame, 3-frame timeout.
module tb_fb_capture_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned AW = 6;
    localparam int unsigned TO = 3;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          mode_live_in, capture_req_in, pix_valid_in, pix_in;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic          frame_done_in, scan_done_in;
    logic          fb_we_out, fb_din_out, frame_ready_out, busy_out;
    logic [AW-1:0] fb_addr_out;
    logic [1:0]    state_out;
    logic [7:0]    frames_captured_out;
    logic          err_short_out, timeout_out;

    int n_tests = 0;
    int n_fail  = 0;

    fb_capture_ctrl #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT_FRAMES(TO)
    ) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .mode_live_in        (mode_live_in),
        .capture_req_in      (capture_req_in),
        .pix_valid_in        (pix_valid_in),
        .hcount_in           (hcount_in),
        .vcount_in           (vcount_in),
        .pix_in              (pix_in),
        .frame_done_in       (frame_done_in),
        .scan_done_in        (scan_done_in),
        .fb_we_out           (fb_we_out),
        .fb_addr_out         (fb_addr_out),
        .fb_din_out          (fb_din_out),
        .frame_ready_out     (frame_ready_out),
        .busy_out            (busy_out),
        .state_out           (state_out),
        .frames_captured_out (frames_captured_out),
        .err_short_out       (err_short_out),
        .timeout_out         (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock edge; inputs set beforehand are consumed, outputs sampled 1ns later
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_pix(input int h, input int v, input logic p);
        pix_valid_in = 1'b1;
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        pix_in       = p;
    endtask

    // n in-range pixels in raster order (wrapping), optional frame_done on the last one
    task automatic feed(input int n, input bit fd_last);
        for (int i = 0; i < n; i++) begin
            set_pix(i % W, (i / W) % H, 1'(i % 3 == 0));
            if (fd_last && i == n - 1) frame_done_in = 1'b1;
            cyc();
        end
        pix_valid_in  = 1'b0;
        frame_done_in = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done_in = 1'b1;
        cyc();
        frame_done_in = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0;
        mode_live_in = 1'b0; capture_req_in = 1'b0; pix_valid_in = 1'b0; pix_in = 1'b0;
        hcount_in = '0; vcount_in = '0; frame_done_in = 1'b0; scan_done_in = 1'b0;
        #12;
        check("rst_we",     32'(fb_we_out), 0);
        check("rst_state",  32'(state_out), 0);
        check("rst_ready",  32'(frame_ready_out), 0);
        check("rst_busy",   32'(busy_out), 0);
        check("rst_frames", 32'(frames_captured_out), 0);
        rst_n_in = 1'b1;
        cyc();

        // live pass-through: h=5 v=2 -> addr 21
        mode_live_in = 1'b1;
        set_pix(5, 2, 1'b1);
        cyc();
        pix_valid_in = 1'b0;
        check("live_we_early", 32'(fb_we_out), 0);
        cyc();
        check("live_we",   32'(fb_we_out), 1);
        check("live_addr", 32'(fb_addr_out), 21);
        check("live_din",  32'(fb_din_out), 1);
        set_pix(8, 2, 1'b1);
        cyc();
        set_pix(3, 4, 1'b1);
        cyc();
        pix_valid_in = 1'b0;
        check("live_hoor_we", 32'(fb_we_out), 0);
        cyc();
        check("live_voor_we", 32'(fb_we_out), 0);

        // live disabled in IDLE
        mode_live_in = 1'b0;
        set_pix(1, 1, 1'b1);
        cyc();
        pix_valid_in = 1'b0;
        cyc();
        check("idle_nolive_we", 32'(fb_we_out), 0);

        // capture_req with frame_done in IDLE -> ARM only
        capture_req_in = 1'b1;
        frame_done_in  = 1'b1;
        cyc();
        capture_req_in = 1'b0;
        frame_done_in  = 1'b0;
        check("race_arm_state", 32'(state_out), 1);
        check("arm_busy",       32'(busy_out), 1);
        pulse_fd();
        check("cap_state", 32'(state_out), 2);

        // full frame, last pixel on the frame_done cycle
        feed(W * H, 1'b1);
        check("hold_state",  32'(state_out), 3);
        check("hold_ready",  32'(frame_ready_out), 1);
        check("hold_busy",   32'(busy_out), 0);
        check("frames_1",    32'(frames_captured_out), 1);
        check("err_full",    32'(err_short_out), 0);
        cyc();
        check("last_pix_we",   32'(fb_we_out), 1);
        check("last_pix_addr", 32'(fb_addr_out), 31);
        check("last_pix_din",  32'(fb_din_out), 0);

        // HOLD: pixels not written, capture_req ignored
        mode_live_in = 1'b1;
        set_pix(2, 1, 1'b1);
        capture_req_in = 1'b1;
        cyc();
        capture_req_in = 1'b0;
        pix_valid_in = 1'b0;
        check("hold_req_state", 32'(state_out), 3);
        cyc();
        check("hold_we", 32'(fb_we_out), 0);
        mode_live_in = 1'b0;

        // release by scan_done
        scan_done_in = 1'b1;
        cyc();
        scan_done_in = 1'b0;
        check("scan_state", 32'(state_out), 0);
        check("scan_ready", 32'(frame_ready_out), 0);
        check("scan_tmo",   32'(timeout_out), 0);

        // re-capture: saturating overcount, short frame, then full frame
        capture_req_in = 1'b1;
        cyc();
        capture_req_in = 1'b0;
        pulse_fd();
        check("cap2_state", 32'(state_out), 2);
        feed(96, 1'b0);
        pulse_fd();
        check("sat_err",   32'(err_short_out), 1);
        check("sat_state", 32'(state_out), 2);
        feed(W * H - 1, 1'b0);
        pulse_fd();
        check("short_err",   32'(err_short_out), 1);
        check("short_state", 32'(state_out), 2);
        cyc();
        check("short_err_clr", 32'(err_short_out), 0);
        feed(W * H, 1'b0);
        pulse_fd();
        check("retry_state",  32'(state_out), 3);
        check("frames_2",     32'(frames_captured_out), 2);

        // timeout after TO frame_done pulses
        pulse_fd();
        pulse_fd();
        check("tmo_pre_state", 32'(state_out), 3);
        check("tmo_pre",       32'(timeout_out), 0);
        pulse_fd();
        check("tmo_pulse", 32'(timeout_out), 1);
        check("tmo_state", 32'(state_out), 0);
        cyc();
        check("tmo_clr", 32'(timeout_out), 0);

        // scan_done coincident with the timing-out frame_done wins
        capture_req_in = 1'b1;
        cyc();
        capture_req_in = 1'b0;
        pulse_fd();
        feed(W * H, 1'b1);
        check("frames_3", 32'(frames_captured_out), 3);
        pulse_fd();
        pulse_fd();
        scan_done_in = 1'b1;
        pulse_fd();
        scan_done_in = 1'b0;
        check("race_scan_state", 32'(state_out), 0);
        check("race_scan_tmo",   32'(timeout_out), 0);

        // async reset mid-capture with a pixel streaming
        capture_req_in = 1'b1;
        cyc();
        capture_req_in = 1'b0;
        pulse_fd();
        set_pix(4, 1, 1'b1);
        cyc();
        cyc();
        check("pre_rst_we", 32'(fb_we_out), 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("arst_we",     32'(fb_we_out), 0);
        check("arst_state",  32'(state_out), 0);
        check("arst_frames", 32'(frames_captured_out), 0);
        check("arst_busy",   32'(busy_out), 0);
        pix_valid_in = 1'b0;
        #10;
        rst_n_in = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
